rr_mask_arbiter: RTL and testbench

RR_MASK_ARBITER -- requirements
Module: rr_mask_arbiter

---
 rtl/rr_mask_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_mask_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mask_arbiter.sv
// Masked round-robin arbiter: 8 requesters, one-hot registered grant.
// Define ARB_TIMEOUT_EN to build the grant watchdog (TIMEOUT_CYCLES).
module rr_mask_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [7:0] req,
    input  logic [2:0] mask_sel,
    input  logic       ack,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] grant_cnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] mask;
    logic [7:0] eligible;
    logic [2:0] winner;
    logic       found;
    logic       release_now;

    // mask[k] keeps requesters 0..k, i.e. 2^(k+1)-1
    always_comb begin
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = (3'(i) <= mask_sel);
        end
        eligible = req & mask;
    end

    always_comb begin
        logic [2:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = ptr;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign release_now = ack | ~req[grant_id];
    assign grant_valid = |grant;
    assign busy        = (state == GRANT);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wdog;
    logic          timeout_q;

    assign timeout = timeout_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_id  <= '0;
            grant_cnt <= '0;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= 8'd1 << winner;
                        grant_id <= winner;
                        wdog     <= '0;
                    end
                end
                GRANT: begin
                    // a release on the expiry edge takes precedence
                    if (release_now) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= grant_id + 3'd1;
                        if (ack) grant_cnt <= grant_cnt + 8'd1;
                    end else if (wdog == CW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        grant     <= '0;
                        ptr       <= grant_id + 3'd1;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_id  <= '0;
            grant_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= 8'd1 << winner;
                        grant_id <= winner;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= grant_id + 3'd1;
                        if (ack) grant_cnt <= grant_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_mask_arbiter.sv
// Scoreboard bench for rr_mask_arbiter: a cycle model pushes expected
// outputs per edge; they are popped and compared one step after the edge.
module tb_rr_mask_arbiter;

    localparam int TO = 15;

    logic       clock;
    logic       clear;
    logic [7:0] req;
    logic [2:0] mask_sel;
    logic       ack;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       busy;
    logic       timeout;
    logic [7:0] grant_cnt;

    rr_mask_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .clear      (clear),
        .req        (req),
        .mask_sel   (mask_sel),
        .ack        (ack),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .busy       (busy),
        .timeout    (timeout),
        .grant_cnt  (grant_cnt)
    );

    typedef struct {
        logic [7:0] grant;
        logic [2:0] id;
        logic       busy;
        logic       to;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // model state
    logic       m_busy;
    logic [2:0] m_ptr;
    logic [7:0] m_grant;
    logic [2:0] m_id;
    logic [7:0] m_cnt;
    logic       m_to;
    int         m_wd;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pick(input logic [7:0] e,
                                        input logic [2:0] p);
        logic [7:0] hi;
        logic [7:0] src;
        logic [2:0] r;
        hi  = e & ~((8'd1 << p) - 8'd1);
        src = (hi != 8'd0) ? hi : e;
        r   = 3'd0;
        for (int i = 7; i >= 0; i--) if (src[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_step();
        int         mk;
        logic [7:0] e;
        exp_t       x;
        if (clear) begin
            m_busy = 0; m_ptr = 0; m_grant = 0; m_id = 0;
            m_cnt = 0; m_to = 0; m_wd = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                mk = (1 << (int'(mask_sel) + 1)) - 1;
                e  = req & mk[7:0];
                if (e != 8'd0) begin
                    m_id    = pick(e, m_ptr);
                    m_grant = 8'd1 << m_id;
                    m_busy  = 1;
                    m_wd    = 0;
                end
            end else if (ack || !req[m_id]) begin
                m_busy  = 0;
                m_grant = 0;
                m_ptr   = m_id + 3'd1;
                if (ack) m_cnt = m_cnt + 8'd1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_wd == TO - 1) begin
                m_busy  = 0;
                m_grant = 0;
                m_ptr   = m_id + 3'd1;
                m_to    = 1;
            end else begin
                m_wd++;
            end
`endif
        end
        x.grant = m_grant;
        x.id    = m_id;
        x.busy  = m_busy;
        x.to    = m_to;
        x.cnt   = m_cnt;
        q.push_back(x);
    endtask

    // one clock: model predicts, DUT steps, scoreboard compares
    task automatic cyc();
        exp_t x;
        model_step();
        @(posedge clock);
        #1;
        x = q.pop_front();
        check("grant", grant, x.grant);
        check("grant_id", grant_id, x.id);
        check("grant_valid", grant_valid, (x.grant != 8'd0));
        check("busy", busy, x.busy);
        check("timeout", timeout, x.to);
        check("grant_cnt", grant_cnt, x.cnt);
    endtask

    task automatic do_clear();
        clear = 1;
        cyc();
        clear = 0;
    endtask

    initial begin
        int held;
        clear = 1; req = 0; mask_sel = 0; ack = 0;
        m_busy = 0; m_ptr = 0; m_grant = 0; m_id = 0;
        m_cnt = 0; m_to = 0; m_wd = 0;
        @(negedge clock);
        cyc();
        check("reset_grant", grant, 8'h00);
        check("reset_cnt", grant_cnt, 0);
        clear = 0;

        // full mask, all requesting: ids rotate 0..7,0
        req = 8'hFF; mask_sel = 3'd7;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("rr_seq_id", grant_id, i % 8);
            ack = 1; cyc(); ack = 0;
        end
        check("rr_seq_cnt", grant_cnt, 9);

        // masked-out requests never win
        do_clear();
        mask_sel = 3'd2; req = 8'hF0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("masked_none", grant, 8'h00);
        end
        req = 8'h0C;
        cyc();
        check("masked_pick", grant, 8'h04);
        ack = 1; cyc(); ack = 0;

        // pointer wrap 7 -> 0, then from ptr 1
        do_clear();
        mask_sel = 3'd7; req = 8'h80;
        cyc();
        check("id7", grant_id, 7);
        ack = 1; cyc(); ack = 0;
        req = 8'h81;
        cyc();
        check("wrap_grant", grant, 8'h01);
        ack = 1; cyc(); ack = 0;
        cyc();
        check("ptr1_grant", grant, 8'h80);

        // clear beats ack during GRANT
        ack = 1; clear = 1;
        cyc();
        clear = 0; ack = 0;
        check("clr_grant", grant, 8'h00);
        check("clr_cnt", grant_cnt, 0);
        req = 8'hFF;
        cyc();
        check("clr_ptr0", grant_id, 0);

        // dropping the granted request releases without counting
        do_clear();
        req = 8'h04;
        cyc();
        check("drop_id", grant_id, 2);
        req = 8'h00;
        cyc();
        check("drop_rel", grant, 8'h00);
        check("drop_cnt", grant_cnt, 0);
        req = 8'h0C;
        cyc();
        check("drop_ptr", grant_id, 3);
        mask_sel = 3'd0; req = 8'h09;
        cyc();
        check("hold_mask", grant_id, 3);
        ack = 1; cyc(); ack = 0;

        // watchdog or indefinite hold
        do_clear();
        req = 8'h01; mask_sel = 3'd0;
        cyc();
        held = 0;
        while (grant_valid && held < 120) begin
            held++;
            cyc();
        end
`ifdef ARB_TIMEOUT_EN
        check("wd_held", held, TO);
        check("wd_pulse", timeout, 1);
        req = 8'h03; mask_sel = 3'd1;
        cyc();
        check("wd_ptr", grant, 8'h02);
        check("wd_cnt", grant_cnt, 0);
        ack = 1; cyc(); ack = 0;
`else
        check("hold_forever", held, 120);
        check("no_timeout", timeout, 0);
`endif

        // random traffic with occasional clear
        for (int i = 0; i < 400; i++) begin
            req      = 8'($urandom);
            mask_sel = 3'($urandom);
            ack      = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 1) == 1 && m_busy) req[m_id] = 1'b1;
            cyc();
        end
        clear = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
